// File: rtl/usb_bus_arb.sv
// Two-master round-robin arbiter for the USB core's 16-bit register bus.
// One transaction per grant, a forced idle (DRAIN) cycle between grants, and an ack timeout.
module usb_bus_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_din,
  output logic [15:0] m0_dout,
  input  logic        m0_cyc,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_din,
  output logic [15:0] m1_dout,
  input  logic        m1_cyc,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] s_addr,
  output logic [15:0] s_din,
  input  logic [15:0] s_dout,
  output logic        s_cyc,
  output logic        s_we,
  input  logic        s_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        s_cyc_q, s_cyc_d;
  logic        s_we_q, s_we_d;
  logic [15:0] s_addr_q, s_addr_d;
  logic [15:0] s_din_q, s_din_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;

  logic        gnt0, gnt1, cur_cyc, tmo;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign cur_cyc = gnt1 ? m1_cyc : m0_cyc;
  assign tmo     = (cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    s_cyc_d      = s_cyc_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_din_d      = s_din_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        // On a tie, the master that did not win last time gets the bus
        if (m0_cyc && (!m1_cyc || last_grant_q)) begin
          state_d      = GNT0;
          s_cyc_d      = 1'b1;
          s_addr_d     = m0_addr;
          s_din_d      = m0_din;
          s_we_d       = m0_we;
          cnt_d        = '0;
          last_grant_d = 1'b0;
        end else if (m1_cyc) begin
          state_d      = GNT1;
          s_cyc_d      = 1'b1;
          s_addr_d     = m1_addr;
          s_din_d      = m1_din;
          s_we_d       = m1_we;
          cnt_d        = '0;
          last_grant_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        s_addr_d = gnt1 ? m1_addr : m0_addr;
        s_din_d  = gnt1 ? m1_din  : m0_din;
        s_we_d   = gnt1 ? m1_we   : m0_we;
        if (s_ack || !cur_cyc || tmo) begin
          state_d = DRAIN;
          s_cyc_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_cyc_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_din_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_cyc_q      <= s_cyc_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_din_q      <= s_din_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s_cyc  = s_cyc_q;
  assign s_we   = s_we_q;
  assign s_addr = s_addr_q;
  assign s_din  = s_din_q;

  // Ack beats timeout; a master that already walked away gets no err
  assign m0_ack  = s_ack & gnt0;
  assign m1_ack  = s_ack & gnt1;
  assign m0_err  = gnt0 & tmo & ~s_ack & m0_cyc;
  assign m1_err  = gnt1 & tmo & ~s_ack & m1_cyc;
  assign m0_dout = gnt0 ? s_dout : 16'h0000;
  assign m1_dout = gnt1 ? s_dout : 16'h0000;

endmodule

// File: tb/tb_usb_bus_arb.sv
// Directed bench for usb_bus_arb: per-cycle vector table plus hand-written
// sequences for alternation, timeout and ack-on-timeout.
module tb_usb_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m0_din, m0_dout, m1_addr, m1_din, m1_dout;
  logic        m0_cyc, m0_we, m0_ack, m0_err, m1_cyc, m1_we, m1_ack, m1_err;
  logic [15:0] s_addr, s_din, s_dout;
  logic        s_cyc, s_we, s_ack;

  int n_chk = 0;
  int n_fail = 0;

  usb_bus_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_dout(m0_dout), .m0_cyc(m0_cyc),
    .m0_we(m0_we), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_dout(m1_dout), .m1_cyc(m1_cyc),
    .m1_we(m1_we), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .s_cyc(s_cyc),
    .s_we(s_we), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        c0, w0;
    logic [15:0] a0, d0;
    logic        c1, w1;
    logic [15:0] a1, d1;
    logic        ack;
    logic [15:0] sdo;
    logic        e_cyc, bus, e_we;
    logic [15:0] e_addr, e_din;
    logic        e_ack0, e_err0;
    logic [15:0] e_do0;
    logic        e_ack1, e_err1;
    logic [15:0] e_do1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic r,
      logic c0, logic w0, logic [15:0] a0, logic [15:0] d0,
      logic c1, logic w1, logic [15:0] a1, logic [15:0] d1,
      logic ack, logic [15:0] sdo,
      logic ec, logic bus, logic ew, logic [15:0] ea, logic [15:0] ed,
      logic ea0, logic ee0, logic [15:0] edo0,
      logic ea1, logic ee1, logic [15:0] edo1);
    vec_t v;
    v.name = nm; v.rst = r;
    v.c0 = c0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.c1 = c1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ack = ack; v.sdo = sdo;
    v.e_cyc = ec; v.bus = bus; v.e_we = ew; v.e_addr = ea; v.e_din = ed;
    v.e_ack0 = ea0; v.e_err0 = ee0; v.e_do0 = edo0;
    v.e_ack1 = ea1; v.e_err1 = ee1; v.e_do1 = edo1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    m0_cyc = v.c0; m0_we = v.w0; m0_addr = v.a0; m0_din = v.d0;
    m1_cyc = v.c1; m1_we = v.w1; m1_addr = v.a1; m1_din = v.d1;
    s_ack = v.ack; s_dout = v.sdo;
    @(negedge clk);
    chk({v.name, ".s_cyc"}, 16'(s_cyc), 16'(v.e_cyc));
    if (v.bus) begin
      chk({v.name, ".s_we"}, 16'(s_we), 16'(v.e_we));
      chk({v.name, ".s_addr"}, s_addr, v.e_addr);
      chk({v.name, ".s_din"}, s_din, v.e_din);
    end
    chk({v.name, ".m0_ack"}, 16'(m0_ack), 16'(v.e_ack0));
    chk({v.name, ".m0_err"}, 16'(m0_err), 16'(v.e_err0));
    chk({v.name, ".m0_dout"}, m0_dout, v.e_do0);
    chk({v.name, ".m1_ack"}, 16'(m1_ack), 16'(v.e_ack1));
    chk({v.name, ".m1_err"}, 16'(m1_err), 16'(v.e_err1));
    chk({v.name, ".m1_dout"}, m1_dout, v.e_do1);
    @(posedge clk); #1;
  endtask

  // Runs one transaction for master m; the slave acks on GNT cycle ack_at (0-based, -1 = never).
  task automatic txn(input int m, input int ack_at, output int hi, output int acks,
                     output int errs, output int err_at, output int stray, output int bus_bad,
                     input logic [15:0] ea, input logic ew);
    int glen = 0;
    bit done = 0;
    hi = 0; acks = 0; errs = 0; err_at = -1; stray = 0; bus_bad = 0;
    if (m == 0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_ack = s_cyc && (glen == ack_at);
      s_dout = 16'h5A00 + 16'(i);
      @(negedge clk);
      if (s_cyc) begin
        hi++; glen++;
        if (s_addr !== ea || s_we !== ew) bus_bad++;
      end
      if (m == 0) begin
        if (m0_ack) begin acks++; done = 1; end
        if (m0_err) begin errs++; err_at = hi; done = 1; end
        if (m1_ack || m1_err) stray++;
      end else begin
        if (m1_ack) begin acks++; done = 1; end
        if (m1_err) begin errs++; err_at = hi; done = 1; end
        if (m0_ack || m0_err) stray++;
      end
      @(posedge clk); #1;
      s_ack = 1'b0;
      if (done) begin m0_cyc = 1'b0; m1_cyc = 1'b0; end
    end
  endtask

  initial begin
    int hi, acks, errs, err_at, stray, bus_bad;
    int cyc, nt, glen, last_ack;
    bit prev;

    rst = 1'b1; s_ack = 1'b0; s_dout = '0;
    m0_cyc = 0; m0_we = 0; m0_addr = '0; m0_din = '0;
    m1_cyc = 0; m1_we = 0; m1_addr = '0; m1_din = '0;
    repeat (2) @(posedge clk);
    #1;

    //         name          rst c0 w0 a0        d0        c1 w1 a1        d1        ack sdo       cyc bus we addr      din       a0 e0 do0       a1 e1 do1
    vq.push_back(mk("reset",     1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m0_req",    0, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m0_g1",     0, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m0_g2",     0, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m0_ack",    0, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 1, 1, 0, 16'h3000, 16'h0000, 1, 0, 16'hA5A5, 0, 0, 16'h0000));
    vq.push_back(mk("m0_drain",  0, 0, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'hA5A5, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("idle",      0, 0, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("drop_req",  0, 1, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("drop_g1",   0, 1, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("drop_cyc",  0, 0, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("late_ack",  0, 0, 1, 16'h3004, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("idle2",     0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m1_req",    0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3800, 16'h1234, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("rst_gnt1",  1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h3800, 16'h1234, 0, 16'h0000, 1, 1, 1, 16'h3800, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("both_req",  0, 1, 0, 16'h3010, 16'h0000, 1, 1, 16'h3800, 16'h1234, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("both_g0",   0, 1, 0, 16'h3010, 16'h0000, 1, 1, 16'h3800, 16'h1234, 1, 16'hCAFE, 1, 1, 0, 16'h3010, 16'h0000, 1, 0, 16'hCAFE, 0, 0, 16'h0000));
    vq.push_back(mk("both_drn",  0, 0, 0, 16'h3010, 16'h0000, 1, 1, 16'h3800, 16'h1234, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m1_idle",   0, 0, 0, 16'h3010, 16'h0000, 1, 1, 16'h3800, 16'h1234, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    vq.push_back(mk("m1_ack",    0, 0, 0, 16'h3010, 16'h0000, 1, 1, 16'h3800, 16'h1234, 1, 16'h0F0F, 1, 1, 1, 16'h3800, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0F0F));
    vq.push_back(mk("end",       0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));

    foreach (vq[i]) apply(vq[i]);

    // Both masters request continuously; slave acks on the 2nd grant cycle.
    m0_addr = 16'h3100; m0_we = 1'b0; m1_addr = 16'h3900; m1_we = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    cyc = 0; nt = 0; glen = 0; last_ack = -1; prev = 0;
    while (nt < 6 && cyc < 100) begin
      if (s_cyc && !prev) begin
        chk($sformatf("alt.order%0d", nt), 16'(s_addr == 16'h3900), 16'(nt % 2));
        if (nt > 0) chk($sformatf("alt.spacing%0d", nt), 16'(cyc - last_ack), 16'd3);
        glen = 0;
      end
      s_ack = s_cyc && (glen == 1);
      s_dout = 16'h7700 + 16'(nt);
      @(negedge clk);
      if (s_ack) begin
        chk($sformatf("alt.ack%0d", nt), {14'h0, m1_ack, m0_ack}, (nt % 2) ? 16'd2 : 16'd1);
        chk($sformatf("alt.dout%0d", nt), (nt % 2) ? m1_dout : m0_dout, 16'h7700 + 16'(nt));
        last_ack = cyc;
        nt++;
      end
      if (s_cyc) glen++;
      prev = s_cyc;
      @(posedge clk); #1;
      cyc++;
    end
    chk("alt.txn_count", 16'(nt), 16'd6);
    m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // m1 write, slave never answers: 16 cycles of s_cyc, err on the 16th.
    m1_addr = 16'h3800; m1_din = 16'h1234; m1_we = 1'b1;
    txn(1, -1, hi, acks, errs, err_at, stray, bus_bad, 16'h3800, 1'b1);
    chk("tmo.cyc_cycles", 16'(hi), 16'd16);
    chk("tmo.err_count", 16'(errs), 16'd1);
    chk("tmo.err_at", 16'(err_at), 16'd16);
    chk("tmo.ack_count", 16'(acks), 16'd0);
    chk("tmo.stray", 16'(stray), 16'd0);
    chk("tmo.bus", 16'(bus_bad), 16'd0);
    chk("tmo.idle_after", 16'(s_cyc), 16'd0);

    // m0 read acked on exactly the timeout cycle: ack wins.
    m0_addr = 16'h3020; m0_we = 1'b0;
    txn(0, 15, hi, acks, errs, err_at, stray, bus_bad, 16'h3020, 1'b0);
    chk("ackto.cyc_cycles", 16'(hi), 16'd16);
    chk("ackto.ack_count", 16'(acks), 16'd1);
    chk("ackto.err_count", 16'(errs), 16'd0);
    chk("ackto.stray", 16'(stray), 16'd0);
    chk("ackto.bus", 16'(bus_bad), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_bus_arb.md
Name: usb_bus_arb

Overview:
- Two-master arbiter in front of the USB core's 16-bit register/EP-status bus (addr/din/dout/cyc/we/ack).
- Lets the SoC CPU (m0) and a secondary agent (m1, e.g. a descriptor/DMA sequencer) share the one core bus port.
- Round-robin grant, one transaction per grant, mandatory idle cycle between transactions so the core's request logic re-arms.
- Ack timeout protects masters against a hung access.

Parameters:
- TIMEOUT, 16: max cycles from s_cyc rise to s_ack before the access is aborted; range 2..255.

Ports:
- clk  in  1  core clock, single clock domain
- rst  in  1  synchronous active-high reset
- m0_addr  in  16  master 0 address
- m0_din  in  16  master 0 write data
- m0_dout  out  16  master 0 read data
- m0_cyc  in  1  master 0 cycle request
- m0_we  in  1  master 0 write enable
- m0_ack  out  1  master 0 acknowledge
- m0_err  out  1  master 0 timeout/abort strobe
- m1_addr, m1_din, m1_dout, m1_cyc, m1_we, m1_ack, m1_err: same widths and meaning for master 1
- s_addr  out  16  bus address to USB core
- s_din  out  16  write data to USB core
- s_dout  in  16  read data from USB core
- s_cyc  out  1  cycle to USB core
- s_we  out  1  write enable to USB core
- s_ack  in  1  acknowledge from USB core

Behaviour:
- Clock/reset: one clock, clk; synchronous active-high reset, rst.
- State machine: IDLE, GNT0, GNT1, DRAIN.
- Reset (rst sampled high, including mid-transaction):
  - state=IDLE; s_cyc=0, s_we=0, s_addr=0, s_din=0.
  - m*_ack=0, m*_err=0; timeout counter=0; last_grant=1, so m0 wins the first tie.
- IDLE:
  - Only m0_cyc=1 -> GNT0. Only m1_cyc=1 -> GNT1.
  - Both high -> grant the master != last_grant.
  - On the grant edge: s_cyc<=1; s_addr/s_din/s_we<=the winner's signals; last_grant<=winner.
  - Latency: m_cyc seen high at edge N -> s_cyc high from cycle N+1.
- GNTx:
  - s_addr/s_din/s_we are registered copies of master x's inputs, updated every cycle.
  - s_cyc is held at 1.
- Ack path (combinational):
  - m_x_ack = s_ack & (state==GNTx).
  - m_x_dout = s_dout when state==GNTx, else 16'h0000.
  - The non-granted master never sees ack, data or err.
- GNTx exit on s_ack=1 -> DRAIN, s_cyc<=0.
- GNTx exit on master x dropping m_x_cyc before ack:
  - -> DRAIN, s_cyc<=0, no ack, no err.
  - A late s_ack arriving in DRAIN is discarded.
- Timeout:
  - 8-bit counter clears on grant and increments each GNT cycle.
  - Reaching TIMEOUT-1 with s_ack=0 -> m_x_err=1 for one cycle, m_x_ack stays 0, s_cyc<=0, -> DRAIN.
  - s_ack and timeout in the same cycle: ack wins, no err.
- DRAIN:
  - Lasts exactly one cycle with s_cyc=0, then IDLE. No arbitration in DRAIN.
  - Minimum back-to-back spacing: ack at cycle K -> next s_cyc at K+3.
- Master obligations:
  - Hold addr/din/we stable while cyc is high.
  - Drop cyc the cycle after ack/err. A cyc still high in IDLE is treated as a new request.
- Fairness: with both masters continuously requesting, grants strictly alternate; no master waits more than one transaction.
- Outputs m*_ack, m*_err are single-cycle pulses; never asserted in IDLE or DRAIN.

Test Plan:
- Reset then m0 read (addr 16'h3000): s_ack at 3rd GNT0 cycle with s_dout=16'hA5A5 -> m0_ack one cycle, m0_dout=16'hA5A5, s_cyc low next cycle, m1_dout=0.
- m0_cyc and m1_cyc raised on the same edge after reset -> m0 granted first; m1 granted next.
  - Continuous requests over 6 transactions -> grant order 0,1,0,1,0,1.
  - Each s_cyc rises exactly 3 cycles after the previous ack.
- m1 write (addr 16'h3800, din 16'h1234), slave never acks, TIMEOUT=16:
  - s_cyc high exactly 16 cycles, m1_err pulse on the 16th, no m1_ack, then DRAIN and IDLE.
- m0 drops cyc mid-GNT0 while s_ack arrives the following cycle -> no m0_ack, no m0_err; the late ack is ignored in DRAIN.
- rst asserted during GNT1 with s_cyc=1 -> next cycle s_cyc=0, state IDLE.
  - Subsequent simultaneous requests grant m0 first.
- s_ack coincident with timeout cycle -> m_ack=1, m_err=0.
